// File: rtl/fp_decode_seq.sv
// fp_decode_seq: sequential decoder from a small sign/exponent/significand
// float to a 13-bit two's-complement linear value,
//   out_d = (in_s ? -1 : +1) * (in_f << in_e).
// The significand is shifted left one bit per clock.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word {in_s, in_e, in_f} present
//   in_ready   block can accept an input word (high only in IDLE)
//   in_s       sign, 1 = negative
//   in_e       exponent 0..7
//   in_f       unsigned significand 0..31
//   out_valid  out_d holds a completed conversion
//   out_ready  consumer accepts out_d (only meaningful in DONE)
//   out_d      13-bit two's-complement result, held until next completion
module fp_decode_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_s,
  input  logic [2:0]  in_e,
  input  logic [4:0]  in_f,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_d
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_nx;
  logic        sign;
  logic [11:0] mag;
  logic [2:0]  cnt;
  logic [12:0] mag_ext;

  assign mag_ext = {1'b0, mag};

  // Decoded straight from the state register: no path from in_valid/out_ready.
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = SHIFT;
      SHIFT:   if (cnt == 3'd0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign      <= 1'b0;
      mag       <= '0;
      cnt       <= '0;
      out_d     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_s;
            mag  <= {7'b0, in_f};
            cnt  <= in_e;
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            mag <= mag << 1;
            cnt <= cnt - 3'd1;
          end else begin
            // Negating a zero magnitude wraps back to zero: no negative zero.
            out_d     <= sign ? (~mag_ext + 13'd1) : mag_ext;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/fp_decode_seq.md
FP_DECODE_SEQ -- requirements
Module: fp_decode_seq

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word {in_s, in_e, in_f} is present.
- in_ready  output  1  block can accept an input word.
- in_s  input  1  sign of the floating-point value (1 = negative).
- in_e  input  3  exponent, range 0..7.
- in_f  input  5  significand, unsigned, range 0..31.
- out_valid  output  1  out_d holds a completed conversion.
- out_ready  input  1  consumer accepts out_d.
- out_d  output  13  two's-complement linear value.
REQ-002 The block SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
REQ-003 The block SHALL compute out_d = (in_s ? -1 : +1) * (in_f << in_e), as a 13-bit two's-complement value.
REQ-004 Magnitude SHALL be held in a 12-bit register; the maximum is 31<<7 = 3968, so no overflow occurs and out_d needs no saturation.
REQ-005 in_s=1 with a zero magnitude SHALL produce out_d = 0 (no negative zero).
REQ-006 Inputs with in_f[4]=0 and in_e>0 (non-normalized) SHALL be decoded literally per REQ-003.
REQ-007 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-008 IDLE behaviour:
- in_ready = 1.
- On in_valid=1 at an edge: latch sign=in_s, mag={7'b0,in_f}, cnt=in_e, and go to SHIFT.
- If in_valid=0, stay in IDLE.
REQ-009 SHIFT behaviour, once per edge:
- If cnt != 0: mag <= mag<<1, cnt <= cnt-1, stay in SHIFT.
- If cnt = 0: register out_d = sign ? (~{1'b0,mag}+1) : {1'b0,mag}, set out_valid=1, go to DONE.
REQ-010 Latency: out_valid SHALL rise exactly in_e+1 clock edges after the accepting edge.
REQ-011 in_ready SHALL be 0 in SHIFT and DONE.
REQ-012 in_valid and the input fields SHALL be ignored while in_ready=0.
REQ-013 DONE behaviour:
- out_d and out_valid stay stable while out_ready=0.
- On out_ready=1 at an edge: out_valid goes to 0 and the FSM returns to IDLE.
- in_ready goes high in the cycle after the handshake, so there is no same-cycle turnaround.
REQ-014 out_ready SHALL have no effect outside DONE.
REQ-015 out_d SHALL keep its last value after the output handshake until the next conversion completes.
REQ-016 in_ready and out_valid SHALL be driven directly from registered state, with no combinational path from in_valid or out_ready.
REQ-017 Back-to-back throughput SHALL be one conversion per in_e+3 cycles with out_ready held at 1.

Reset
REQ-018 While rst_n=0 the block SHALL immediately, without waiting for clk, set:
- state = IDLE
- out_valid = 0
- out_d = 0
- mag = 0, cnt = 0, sign = 0.
REQ-019 in_ready SHALL be 1 during reset and in the first cycle after rst_n deasserts.
REQ-020 Reset asserted in SHIFT or DONE SHALL abort the conversion with no out_valid pulse; the aborted result is discarded.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- Zero exponent: S=0, E=0, F=22 -> out_d=13'h0016; out_valid 1 edge after accept.
- Maximum: S=0, E=7, F=31 -> out_d=13'h0F80 (3968); out_valid 8 edges after accept.
- Negative: S=1, E=3, F=17 -> out_d=13'h1F78 (-136); out_valid 4 edges after accept.
- Negative zero: S=1, E=5, F=0 -> out_d=13'h0000; out_valid 6 edges after accept.
- Backpressure: out_ready=0 for 5 cycles in DONE while in_valid toggles with new data -> out_d and out_valid stay stable, in_ready=0, the new data is not captured; after out_ready=1, in_ready=1 on the next cycle.
- Reset mid-SHIFT: assert rst_n=0 two cycles after accepting E=6 -> out_valid=0, out_d=0, in_ready=1 immediately, with no result later.
